seg7_display: RTL and testbench
===============================

# seg7_display

Memory-mapped 8-digit seven-segment display controller on the CPU's IO bus, downstream of the memory/IO address decoder alongside the LED block. The CPU writes a 32-bit value and a mode word through 16-bit IO stores. The block shows the value as 8 hex digits, or as 5 decimal digits produced by a sequential binary-to-BCD converter. It time-multiplexes the digits with an internal scan counter.

## Interface
- SCAN_DIV, 50000: clock cycles each digit is enabled per scan step; minimum 2.
- clock  in  1  system clock, the same clock1 domain as the CPU datapath.
- rst  in  1  reset, asynchronous, active-low.
- segwrite  in  1  write strobe from the IO decoder, active high.
- segcs  in  1  chip select, active high. A write occurs only when segwrite and segcs are both 1.
- segaddr  in  2  register select:
  - 00: value low
  - 01: value high
  - 10: mode
  - 11: ignored
- segwdata  in  16  write data.
- seg_en  out  8  digit enables, active-low. Bit 0 is the rightmost, least significant digit.
- seg_out  out  8  segments {dp,g,f,e,d,c,b,a}, active-low. dp is always 1.
- busy  out  1  decimal conversion in progress.

## Operation
- Registers, all cleared by reset:
  - val_lo[15:0], val_hi[15:0]
  - mode[2:0]: bit0 decimal, bit1 leading-zero blank, bit2 display off
  - bcd_disp[19:0]
- Register write: mode takes segwdata[2:0]. The written register updates on the sampling edge.
- Conversion start: an accepted write to addr 00, or to addr 10 that leaves mode[0]=1, starts a conversion of the post-write val_lo. An addr-01 write never starts a conversion.
- Converter: double-dabble, one source bit per cycle, MSB first, 16 shift steps.
  - Before each shift, add 3 to every BCD nibble that is ≥5.
  - Operands are a 16-bit shift copy and a 20-bit BCD accumulator.
  - After step 16, copy the accumulator into bcd_disp.
- States:
  - IDLE → CONV on start.
  - CONV stays in CONV with an internal step counter 0..15. It returns to IDLE after step 15.
  - A start during CONV restarts from step 0 with the new val_lo.
- Hex mode (mode[0]=0): digit i shows nibble i of {val_hi,val_lo}, live from the registers. Glyphs 0-9, A, b, C, d, E, F.
- Decimal mode (mode[0]=1):
  - Digits 0..4 show bcd_disp nibbles; digits 5..7 are blank.
  - During CONV the old bcd_disp stays displayed.
- Leading-zero blank (mode[1]=1): blank every digit above the most significant nonzero displayed digit. Digit 0 always shows.
- Display off (mode[2]=1): seg_en=8'hFF. Scanning and conversion continue.
- Segment codes:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8
  - 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E
  - blank=FF
- Scan:
  - prescaler counts 0..SCAN_DIV-1.
  - On wrap, digit index 0..7 increments, wrapping 7→0.
  - seg_en = ~(1<<index).
  - seg_out is the registered code of the current index, so seg_en and seg_out change on the same edge.

## Timing
- Reset (rst=0, asynchronous):
  - seg_en=8'hFF, seg_out=8'hFF, busy=0.
  - All registers, prescaler, digit index and converter return to 0 / IDLE.
- First edge after release: prescaler begins. After SCAN_DIV edges, digit 0 is enabled.
- Write at edge k:
  - The register holds the new value after edge k.
  - seg_out reflects it no later than edge k+1 while that digit is selected.
- Conversion:
  - Start sampled at edge k.
  - busy=1 after edge k. Shifts occur on edges k+1..k+16.
  - After edge k+16, bcd_disp is valid and busy=0. busy is high exactly 16 cycles.
- Restart at edge j during CONV: busy stays 1, and bcd_disp updates after edge j+16.
- Reset mid-conversion: aborts immediately, busy=0, bcd_disp=0.
- Writes with segcs=0 or segaddr=11 have no effect.

## Test plan
- SCAN_DIV=4, reset pulse:
  - Outputs are FF/FF/0 during reset.
  - After release, seg_en walks FE, FD, FB … 7F, FE, with each value held 4 cycles.
- Hex: write lo=ABCD, hi=1234, mode=0:
  - Digits 0..7 show D, C, B, A, 4, 3, 2, 1.
  - Codes A1, C6, 83, 88, 99, B0, A4, F9.
- Decimal: mode=001, then write lo=FFFF:
  - busy is high exactly 16 cycles.
  - Digits 0..4 show 5, 3, 5, 5, 6; digits 5..7 are FF.
- Leading blank: mode=011, lo=0x0007:
  - After conversion, digit 0 = F8 and digits 1..7 = FF.
  - lo=0x0000 shows C0 on digit 0 only.
- Restart: write lo=100, then lo=42 eight cycles later:
  - busy is high 24 cycles total.
  - Final display is 42; 100 never appears.
- Reset mid-conversion, plus a write with segcs=0:
  - busy drops asynchronously and digits read 0.
  - The segcs=0 write leaves all registers unchanged.

Source files
------------

// File: rtl/seg7_display.sv
// Eight-digit multiplexed seven-segment controller on the CPU IO bus.
// Shows a 32-bit value in hex, or val_lo in decimal via a serial double-dabble converter.
module seg7_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        segwrite,
    input  logic        segcs,
    input  logic [1:0]  segaddr,
    input  logic [15:0] segwdata,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out,
    output logic        busy
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    localparam logic [1:0] ADDR_LO   = 2'b00;
    localparam logic [1:0] ADDR_HI   = 2'b01;
    localparam logic [1:0] ADDR_MODE = 2'b10;

    localparam logic [7:0] GLYPH_BLANK = 8'hFF;

    typedef enum logic {
        IDLE,
        CONV
    } conv_state_t;

    // ---------------------------------------------------------------
    // Register file
    // ---------------------------------------------------------------
    logic [15:0] val_lo;
    logic [15:0] val_hi;
    logic [2:0]  mode;
    logic [19:0] bcd_disp;

    logic        wr_en;
    logic        start;
    logic [15:0] conv_src;

    assign wr_en = segwrite && segcs;

    // A mode write starts a conversion only when it leaves decimal mode selected.
    assign start = wr_en && ((segaddr == ADDR_LO) ||
                             (segaddr == ADDR_MODE && segwdata[0]));

    assign conv_src = (segaddr == ADDR_LO) ? segwdata : val_lo;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            val_lo <= '0;
            val_hi <= '0;
            mode   <= '0;
        end else if (wr_en) begin
            case (segaddr)
                ADDR_LO:   val_lo <= segwdata;
                ADDR_HI:   val_hi <= segwdata;
                ADDR_MODE: mode   <= segwdata[2:0];
                default:   ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Binary-to-BCD converter
    // ---------------------------------------------------------------
    conv_state_t state;
    logic [3:0]  step;
    logic [15:0] shift;
    logic [19:0] acc;
    logic [19:0] acc_next;

    function automatic logic [19:0] dabble_step(input logic [19:0] a, input logic b);
        logic [19:0] r;
        r = a;
        for (int n = 0; n < 5; n++) begin
            if (r[4*n +: 4] >= 4'd5)
                r[4*n +: 4] = r[4*n +: 4] + 4'd3;
        end
        return (r << 1) | {19'd0, b};
    endfunction

    assign acc_next = dabble_step(acc, shift[15]);

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            step     <= '0;
            shift    <= '0;
            acc      <= '0;
            busy     <= 1'b0;
            bcd_disp <= '0;
        end else if (start) begin
            // A new start wins over an in-flight conversion and restarts it.
            state <= CONV;
            step  <= '0;
            shift <= conv_src;
            acc   <= '0;
            busy  <= 1'b1;
        end else if (state == CONV) begin
            shift <= {shift[14:0], 1'b0};
            acc   <= acc_next;
            step  <= step + 4'd1;
            if (step == 4'd15) begin
                state    <= IDLE;
                busy     <= 1'b0;
                bcd_disp <= acc_next;
            end
        end
    end

    // ---------------------------------------------------------------
    // Scan timing
    // ---------------------------------------------------------------
    logic [PW-1:0] presc;
    logic [2:0]    idx;
    logic          scan_on;
    logic          wrap;
    logic          scan_on_next;
    logic [2:0]    idx_next;

    assign wrap         = (presc == PRESC_LAST);
    assign scan_on_next = scan_on || wrap;
    // The first wrap only enables digit 0; later wraps advance the index.
    assign idx_next     = (wrap && scan_on) ? idx + 3'd1 : idx;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            presc   <= '0;
            idx     <= '0;
            scan_on <= 1'b0;
        end else begin
            presc   <= wrap ? '0 : presc + PW'(1);
            idx     <= idx_next;
            scan_on <= scan_on_next;
        end
    end

    // ---------------------------------------------------------------
    // Digit selection, leading-zero blanking and glyph lookup
    // ---------------------------------------------------------------
    function automatic logic [7:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0:    return 8'hC0;
            4'h1:    return 8'hF9;
            4'h2:    return 8'hA4;
            4'h3:    return 8'hB0;
            4'h4:    return 8'h99;
            4'h5:    return 8'h92;
            4'h6:    return 8'h82;
            4'h7:    return 8'hF8;
            4'h8:    return 8'h80;
            4'h9:    return 8'h90;
            4'hA:    return 8'h88;
            4'hB:    return 8'h83;
            4'hC:    return 8'hC6;
            4'hD:    return 8'hA1;
            4'hE:    return 8'h86;
            default: return 8'h8E;
        endcase
    endfunction

    logic [31:0] value;
    logic [3:0]  digits [8];
    logic [7:0]  shown;
    logic [7:0]  blank;
    logic        nz_seen;
    logic [7:0]  next_code;

    assign value = {val_hi, val_lo};

    always_comb begin
        // NOTE: every variable gets a default before any conditional write so no latch is inferred.
        shown   = '0;
        blank   = '0;
        nz_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            digits[i] = '0;
            if (!mode[0]) begin
                digits[i] = value[4*i +: 4];
                shown[i]  = 1'b1;
            end else if (i < 5) begin
                digits[i] = bcd_disp[4*i +: 4];
                shown[i]  = 1'b1;
            end
        end
        // NOTE: blocking assignments here make nz_seen a running OR from the top digit downward.
        for (int i = 7; i >= 0; i--) begin
            nz_seen  = nz_seen || (shown[i] && digits[i] != 4'd0);
            blank[i] = !shown[i] || (mode[1] && !nz_seen && i != 0);
        end
        next_code = blank[idx_next] ? GLYPH_BLANK : seg_code(digits[idx_next]);
    end

    // Enable and segment registers load together so they always agree on the digit.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            seg_en  <= 8'hFF;
            seg_out <= GLYPH_BLANK;
        end else begin
            seg_en  <= (!scan_on_next || mode[2]) ? 8'hFF : ~(8'd1 << idx_next);
            seg_out <= scan_on_next ? next_code : GLYPH_BLANK;
        end
    end

endmodule

// File: tb/tb_seg7_display.sv
// Directed self-checking bench for seg7_display with a short scan divider.
// Expected glyphs and timings are hand-computed constants.
module tb_seg7_display;

    localparam int SCAN_DIV = 4;

    logic        clock = 1'b0;
    logic        rst = 1'b0;
    logic        segwrite = 1'b0;
    logic        segcs = 1'b0;
    logic [1:0]  segaddr = '0;
    logic [15:0] segwdata = '0;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] got [8];

    seg7_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clock    (clock),
        .rst      (rst),
        .segwrite (segwrite),
        .segcs    (segcs),
        .segaddr  (segaddr),
        .segwdata (segwdata),
        .seg_en   (seg_en),
        .seg_out  (seg_out),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] en_for(input int i);
        logic [7:0] one;
        one = 8'd1 << i;
        return ~one;
    endfunction

    // One bus write; returns 1 ns after the sampling edge.
    task automatic wr(input logic [1:0] a, input logic [15:0] d, input logic cs);
        segwrite = 1'b1;
        segcs    = cs;
        segaddr  = a;
        segwdata = d;
        @(posedge clock);
        #1;
        segwrite = 1'b0;
        segcs    = 1'b0;
    endtask

    task automatic busy_len(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            @(posedge clock);
            #1;
            cnt++;
        end
    endtask

    task automatic wait_idle(input string tag);
        int cnt;
        busy_len(cnt);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    task automatic read_digits();
        for (int i = 0; i < 8; i++) got[i] = 8'h00;
        for (int c = 0; c < 40; c++) begin
            @(posedge clock);
            #1;
            for (int i = 0; i < 8; i++)
                if (seg_en == en_for(i)) got[i] = seg_out;
        end
    endtask

    task automatic check_digits(input string tag, input logic [63:0] exp_codes);
        read_digits();
        for (int i = 0; i < 8; i++)
            check($sformatf("%s_d%0d", tag, i), got[i], exp_codes[8*i +: 8]);
    endtask

    initial begin
        int cnt;
        logic saw_100;
        logic [7:0] exp_en;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_en", seg_en, 8'hFF);
        check("rst_out", seg_out, 8'hFF);
        check("rst_busy", busy, 1'b0);

        // Scan walk: FF for 3 edges, then FE, FD, ... 7F, FE each held 4 edges
        @(negedge clock);
        rst = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clock);
            #1;
            exp_en = (n < SCAN_DIV) ? 8'hFF : en_for((n / SCAN_DIV - 1) % 8);
            check($sformatf("scan_e%0d", n), seg_en, exp_en);
        end

        // Hex display of 0x1234ABCD
        wr(2'b00, 16'hABCD, 1'b1);
        check("hex_lo_start", busy, 1'b1);
        wr(2'b01, 16'h1234, 1'b1);
        wr(2'b10, 16'h0000, 1'b1);
        check_digits("hex", 64'hF9A4B099_8883C6A1);
        wait_idle("hex");

        // Decimal display of 65535
        wr(2'b10, 16'h0001, 1'b1);
        check("mode_start", busy, 1'b1);
        busy_len(cnt);
        check("mode_busy_len", cnt, 16);
        wr(2'b00, 16'hFFFF, 1'b1);
        check("dec_start", busy, 1'b1);
        busy_len(cnt);
        check("dec_busy_len", cnt, 16);
        check_digits("dec", 64'hFFFFFF82_9292B092);

        // Leading-zero blanking
        wr(2'b10, 16'h0003, 1'b1);
        wait_idle("lz_mode");
        wr(2'b00, 16'h0007, 1'b1);
        wait_idle("lz7");
        check_digits("lz7", 64'hFFFFFFFF_FFFFFFF8);
        wr(2'b00, 16'h0000, 1'b1);
        wait_idle("lz0");
        check_digits("lz0", 64'hFFFFFFFF_FFFFFFC0);

        // Restart: 100 then 42 eight cycles later
        saw_100 = 1'b0;
        wr(2'b00, 16'd100, 1'b1);
        cnt = 0;
        repeat (7) begin
            @(posedge clock);
            #1;
            cnt++;
            if (seg_en == 8'hFB && seg_out == 8'hF9) saw_100 = 1'b1;
        end
        wr(2'b00, 16'd42, 1'b1);
        cnt++;
        check("rst_conv_busy", busy, 1'b1);
        while (busy && cnt < 100) begin
            @(posedge clock);
            #1;
            cnt++;
            if (seg_en == 8'hFB && seg_out == 8'hF9) saw_100 = 1'b1;
        end
        check("restart_busy_len", cnt, 24);
        check_digits("restart", 64'hFFFFFFFF_FFFF99A4);
        check("restart_no_100", saw_100, 1'b0);

        // Reset in the middle of a conversion
        wr(2'b00, 16'd9999, 1'b1);
        repeat (5) @(posedge clock);
        #1;
        check("mid_busy", busy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_en", seg_en, 8'hFF);
        check("mid_rst_out", seg_out, 8'hFF);
        @(negedge clock);
        rst = 1'b1;

        // Writes without chip select, or to the unused address, are ignored
        wr(2'b00, 16'h5678, 1'b0);
        check("nocs_lo_busy", busy, 1'b0);
        wr(2'b01, 16'h1234, 1'b0);
        wr(2'b10, 16'h0004, 1'b0);
        wr(2'b11, 16'hFFFF, 1'b1);
        check("addr3_busy", busy, 1'b0);
        check_digits("post_rst", 64'hC0C0C0C0_C0C0C0C0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
